// File: rtl/cu_pkg.sv
// Control-unit shared types: the architectural flag register layout.
package cu_pkg;

  typedef struct packed {
    logic       s;
    logic       z;
    logic [2:0] rsvd;
    logic       v;
    logic       n;
    logic       c;
  } f_register;

endpackage

// File: rtl/wb_pkg.sv
// ALU writeback shared definitions: FSM states, register indices, pair helpers.
package wb_pkg;

  typedef enum logic [1:0] {IDLE, WR8, WRH, WRL} wb_state_t;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_A = 3'd7;

  // Pair 2'b11 would be A/F; F lives in f_reg, so only A is written.
  localparam logic [1:0] PAIR_AF        = 2'b11;
  localparam logic [7:0] FLAG_LIVE_MASK = 8'hC7;

  function automatic logic [2:0] pair_hi(input logic [1:0] p);
    return {p, 1'b0};
  endfunction

  function automatic logic [2:0] pair_lo(input logic [1:0] p);
    return {p, 1'b1};
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU result writeback: byte/pair register-file write FSM plus the flag register.
// Optional ALU_WB_FLAG_MASK_EN adds a per-bit flag write mask port.
module alu_writeback
  import cu_pkg::*;
  import wb_pkg::*;
#(
  parameter logic [7:0] FLAG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_result,
  input  f_register   alu_flag,
  input  logic [2:0]  dest,
  input  logic        wide,
  input  logic        flag_we,
`ifdef ALU_WB_FLAG_MASK_EN
  input  logic [7:0]  flag_mask,
`endif
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output f_register   f_reg,
  output logic        cin
);

  wb_state_t  r_state, w_state_nxt;
  logic       r_we, w_we_nxt;
  logic [2:0] r_waddr, w_waddr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic [1:0] r_pair, w_pair_nxt;
  logic [7:0] r_lo, w_lo_nxt;
  f_register  r_f;
  logic [7:0] w_f_nxt;
  logic       w_xfer;
  logic [7:0] w_fmask;

  assign in_ready = (r_state != WRH);
  assign w_xfer   = in_valid & in_ready;

`ifdef ALU_WB_FLAG_MASK_EN
  assign w_fmask = flag_mask;
`else
  assign w_fmask = 8'hFF;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_pair_nxt  = r_pair;
    w_lo_nxt    = r_lo;
    case (r_state)
      WRH: begin
        w_state_nxt = WRL;
        w_we_nxt    = 1'b1;
        w_waddr_nxt = pair_lo(r_pair);
        w_wdata_nxt = r_lo;
      end
      default: begin
        if (w_xfer) begin
          w_we_nxt = 1'b1;
          if (wide && (dest[2:1] != PAIR_AF)) begin
            // Low byte is parked so input changes during WRH are ignored.
            w_state_nxt = WRH;
            w_waddr_nxt = pair_hi(dest[2:1]);
            w_wdata_nxt = alu_result[15:8];
            w_pair_nxt  = dest[2:1];
            w_lo_nxt    = alu_result[7:0];
          end else begin
            w_state_nxt = WR8;
            w_waddr_nxt = wide ? REG_A : dest;
            w_wdata_nxt = alu_result[7:0];
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_f_nxt = r_f;
    if (w_xfer && flag_we)
      w_f_nxt = ((r_f & ~w_fmask) | (alu_flag & w_fmask)) & FLAG_LIVE_MASK;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_waddr <= 3'd0;
      r_wdata <= 8'd0;
      r_pair  <= 2'd0;
      r_lo    <= 8'd0;
      r_f     <= FLAG_RESET & FLAG_LIVE_MASK;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_pair  <= w_pair_nxt;
      r_lo    <= w_lo_nxt;
      r_f     <= w_f_nxt;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign f_reg    = r_f;
  assign cin      = r_f.c;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed cases then random traffic
// against a queue-of-pending-byte-writes reference model.
module tb_alu_writeback;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_result;
  f_register   alu_flag;
  logic [2:0]  dest;
  logic        wide;
  logic        flag_we;
  logic [7:0]  flag_mask;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  f_register   f_reg;
  logic        cin;

  always #5 clk = ~clk;

  alu_writeback #(.FLAG_RESET(8'hFF)) dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flag(alu_flag), .dest(dest), .wide(wide),
    .flag_we(flag_we),
`ifdef ALU_WB_FLAG_MASK_EN
    .flag_mask(flag_mask),
`endif
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .f_reg(f_reg), .cin(cin)
  );

  // Reference: bytes still to be written, head is the one on the port now.
  logic [10:0] m_q[$];
  logic [7:0]  m_f;
  logic        m_after_rst;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input logic rst_n, input logic v, input logic [15:0] res,
                     input logic [7:0] flg, input logic [2:0] d, input logic w,
                     input logic fwe, input logic [7:0] msk);
    logic       m_ready, xfer;
    logic [1:0] pr;
    nRst = rst_n; in_valid = v; alu_result = res; alu_flag = flg;
    dest = d; wide = w; flag_we = fwe; flag_mask = msk;
    @(negedge clk);
    m_ready = (m_q.size() <= 1);
    chk("in_ready", {15'd0, in_ready}, {15'd0, m_ready});
    chk("rf_we", {15'd0, rf_we}, {15'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("rf_waddr", {13'd0, rf_waddr}, {13'd0, m_q[0][10:8]});
      chk("rf_wdata", {8'd0, rf_wdata}, {8'd0, m_q[0][7:0]});
    end else if (m_after_rst) begin
      chk("rst_waddr", {13'd0, rf_waddr}, 16'd0);
      chk("rst_wdata", {8'd0, rf_wdata}, 16'd0);
    end
    chk("f_reg", {8'd0, f_reg}, {8'd0, m_f});
    chk("cin", {15'd0, cin}, {15'd0, m_f[0]});
    xfer = v && m_ready;
    @(posedge clk);
    m_after_rst = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_f = 8'hFF & 8'hC7;
      m_after_rst = 1'b1;
    end else begin
      if (m_q.size() != 0) void'(m_q.pop_front());
      if (xfer) begin
        pr = d[2:1];
        if (w && pr == 2'b11) m_q.push_back({3'd7, res[7:0]});
        else if (w) begin
          m_q.push_back({pr, 1'b0, res[15:8]});
          m_q.push_back({pr, 1'b1, res[7:0]});
        end else m_q.push_back({d, res[7:0]});
`ifdef ALU_WB_FLAG_MASK_EN
        if (fwe) m_f = ((m_f & ~msk) | (flg & msk)) & 8'hC7;
`else
        if (fwe) m_f = flg & 8'hC7;
`endif
      end
    end
    #1;
  endtask

  initial begin
    m_f = 8'h00; m_after_rst = 1'b0;
    nRst = 1'b0; in_valid = 1'b0; alu_result = '0; alu_flag = '0;
    dest = '0; wide = 1'b0; flag_we = 1'b0; flag_mask = 8'hFF;
    // Two reset cycles, then model is synchronised with the DUT.
    @(posedge clk); @(posedge clk); #1;
    m_q.delete(); m_f = 8'hC7; m_after_rst = 1'b1;
    chk("reset_f_reg", {8'd0, f_reg}, 16'h00C7);

    // 8-bit write to A with flags 0x81
    cyc(1, 1, 16'h00A5, 8'h81, 3'd7, 0, 1, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    chk("f_after_8bit", {8'd0, f_reg}, 16'h0081);
    // 16-bit write to HL, inputs scrambled during WRH
    cyc(1, 1, 16'h1234, 8'h00, 3'd4, 1, 0, 8'hFF);
    cyc(1, 1, 16'hFFFF, 8'hFF, 3'd1, 0, 1, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    // three back-to-back byte writes
    cyc(1, 1, 16'h0011, 8'h00, 3'd0, 0, 0, 8'hFF);
    cyc(1, 1, 16'h0022, 8'h00, 3'd1, 0, 0, 8'hFF);
    cyc(1, 1, 16'h0033, 8'h00, 3'd2, 0, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    // wide to pair 11 -> only low byte to A
    cyc(1, 1, 16'hBEEF, 8'h00, 3'd6, 1, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    // flag mask: clear, then write carry only
    cyc(1, 1, 16'h0000, 8'h00, 3'd0, 0, 1, 8'hFF);
    cyc(1, 1, 16'h0000, 8'hFF, 3'd0, 0, 1, 8'h01);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    // reset while in WRH aborts the low byte
    cyc(1, 1, 16'hCAFE, 8'h00, 3'd2, 1, 0, 8'hFF);
    cyc(0, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);
    cyc(1, 0, 16'h0000, 8'h00, 3'd0, 0, 0, 8'hFF);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 3) != 0,
          16'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
